// File: rtl/sobel_column_feeder_pkg.sv
// Shared definitions for the Sobel-X column feeder.
// - PIX_W / COL_W : default pixel width and packed column width
// - feeder_state_e : frame-tracking FSM states
// - col_pack       : packs {top, mid, bot}; top lands in [3W-1:2W], bot in [W-1:0]
package sobel_column_feeder_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned COL_W = 3 * PIX_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } feeder_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } column_t;

  function automatic logic [COL_W-1:0] col_pack(input logic [PIX_W-1:0] top,
                                                input logic [PIX_W-1:0] mid,
                                                input logic [PIX_W-1:0] bot);
    column_t c;
    c.top = top;
    c.mid = mid;
    c.bot = bot;
    return c;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: asynchronous read and synchronous write
// at the same address, so a read-modify-write happens in a single cycle.
// Ports:
//   clk   - rising-edge clock
//   addr  - pixel column address (read and write)
//   we    - write enable
//   wdata - pixel written at addr on the clock edge
//   rdata - pixel currently stored at addr (combinational)
module sobel_line_buffer #(
  parameter int unsigned DEPTH  = 768,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset; stale contents are masked upstream.
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_column_feeder.sv
// Streaming 3x3 window producer for a Sobel-X kernel. Pixels arrive in raster
// order; two line buffers plus a two-deep column shift register deliver, for
// every interior centre (x,y), the columns at x-1 and x+1.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   pix_in/pix_sof        - input pixel and start-of-frame marker
//   pix_valid/pix_ready   - input handshake (pix_ready is combinational)
//   col_left/col_right    - columns x-1 / x+1, {row y-1, row y, row y+1}, MSB = top
//   col_x/col_y           - window centre coordinates
//   col_last              - final window of the frame
//   col_valid/col_ready   - output handshake
module sobel_column_feeder
  import sobel_column_feeder_pkg::*;
#(
  parameter int unsigned WIDTH          = 768,
  parameter int unsigned HEIGHT         = 512,
  parameter int unsigned BITS_FOR_INDEX = 10,
  parameter int unsigned sizeOfWidth    = PIX_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [sizeOfWidth-1:0]    pix_in,
  input  logic                      pix_sof,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [3*sizeOfWidth-1:0]  col_left,
  output logic [3*sizeOfWidth-1:0]  col_right,
  output logic [BITS_FOR_INDEX-1:0] col_x,
  output logic [BITS_FOR_INDEX-1:0] col_y,
  output logic                      col_last,
  output logic                      col_valid,
  input  logic                      col_ready
);

  localparam int unsigned PW = sizeOfWidth;
  localparam int unsigned CW = 3 * sizeOfWidth;
  localparam int unsigned XW = BITS_FOR_INDEX;
  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [XW-1:0] Y_LAST = XW'(HEIGHT - 1);
  localparam logic [XW-1:0] TWO    = XW'(2);
  localparam logic [XW-1:0] ONE    = XW'(1);

  feeder_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] c0_q, c0_d, c1_q, c1_d;
  logic [CW-1:0] col_left_q, col_left_d, col_right_q, col_right_d;
  logic [XW-1:0] col_x_q, col_x_d, col_y_q, col_y_d;
  logic          col_last_q, col_last_d;
  logic          col_valid_q, col_valid_d;

  logic          accept;
  logic          proc;
  logic [XW-1:0] px, py;
  logic [AW-1:0] lb_addr;
  logic [PW-1:0] top_pix, mid_pix;
  logic [CW-1:0] c_new;

  // Only stall the producer while an untaken output is pending.
  assign pix_ready = !col_valid_q || col_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel is always (0,0); in IDLE anything else is discarded.
  assign proc    = accept && (pix_sof || (state_q == ST_RUN));
  assign px      = pix_sof ? '0 : x_q;
  assign py      = pix_sof ? '0 : y_q;
  assign lb_addr = AW'(px);

  // lb0 holds row y-1 (becomes "mid"), lb1 holds row y-2 (becomes "top").
  sobel_line_buffer #(
    .DEPTH (WIDTH),
    .DATA_W(PW),
    .AW    (AW)
  ) u_lb0 (
    .clk  (clk),
    .addr (lb_addr),
    .we   (proc),
    .wdata(pix_in),
    .rdata(mid_pix)
  );

  sobel_line_buffer #(
    .DEPTH (WIDTH),
    .DATA_W(PW),
    .AW    (AW)
  ) u_lb1 (
    .clk  (clk),
    .addr (lb_addr),
    .we   (proc),
    .wdata(mid_pix),
    .rdata(top_pix)
  );

  assign c_new = {top_pix, mid_pix, pix_in};

  // Next-state: frame position, column history and output register.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    c0_d        = c0_q;
    c1_d        = c1_q;
    col_left_d  = col_left_q;
    col_right_d = col_right_q;
    col_x_d     = col_x_q;
    col_y_d     = col_y_q;
    col_last_d  = col_last_q;
    col_valid_d = col_valid_q;

    if (col_valid_q && col_ready) begin
      col_valid_d = 1'b0;
      col_last_d  = 1'b0;
    end

    if (proc) begin
      state_d = ST_RUN;
      if (px == X_LAST) begin
        x_d = '0;
        if (py == Y_LAST) begin
          y_d     = '0;
          state_d = ST_IDLE;
        end else begin
          y_d = py + ONE;
        end
      end else begin
        x_d = px + ONE;
        y_d = py;
      end

      c0_d = c1_q;
      c1_d = c_new;

      // The x>=2 / y>=2 gate hides stale columns and stale line-buffer rows.
      if ((px >= TWO) && (py >= TWO)) begin
        col_left_d  = c0_q;
        col_right_d = c_new;
        col_x_d     = px - ONE;
        col_y_d     = py - ONE;
        col_last_d  = (px == X_LAST) && (py == Y_LAST);
        col_valid_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      col_left_q  <= '0;
      col_right_q <= '0;
      col_x_q     <= '0;
      col_y_q     <= '0;
      col_last_q  <= 1'b0;
      col_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      col_left_q  <= col_left_d;
      col_right_q <= col_right_d;
      col_x_q     <= col_x_d;
      col_y_q     <= col_y_d;
      col_last_q  <= col_last_d;
      col_valid_q <= col_valid_d;
    end
  end

  assign col_left  = col_left_q;
  assign col_right = col_right_q;
  assign col_x     = col_x_q;
  assign col_y     = col_y_q;
  assign col_last  = col_last_q;
  assign col_valid = col_valid_q;

endmodule

// File: tb/tb_sobel_column_feeder.sv
// Bench for sobel_column_feeder: a 4x4 instance for the directed scenarios and
// an 8x6 instance for randomized valid/ready traffic, both checked against a
// window model built directly from the image array.
module tb_sobel_column_feeder;
  import sobel_column_feeder_pkg::*;

  localparam int unsigned XW = 10;

  typedef struct packed {
    logic [23:0]   l;
    logic [23:0]   r;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic          last;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]    pix_in    [2];
  logic          pix_sof   [2];
  logic          pix_valid [2];
  logic          pix_ready [2];
  logic [23:0]   col_left  [2];
  logic [23:0]   col_right [2];
  logic [XW-1:0] col_x     [2];
  logic [XW-1:0] col_y     [2];
  logic          col_last  [2];
  logic          col_valid [2];
  logic          col_ready [2];

  sobel_column_feeder #(.WIDTH(4), .HEIGHT(4), .BITS_FOR_INDEX(XW), .sizeOfWidth(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in[0]), .pix_sof(pix_sof[0]),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .col_left(col_left[0]),
    .col_right(col_right[0]), .col_x(col_x[0]), .col_y(col_y[0]), .col_last(col_last[0]),
    .col_valid(col_valid[0]), .col_ready(col_ready[0]));

  sobel_column_feeder #(.WIDTH(8), .HEIGHT(6), .BITS_FOR_INDEX(XW), .sizeOfWidth(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in[1]), .pix_sof(pix_sof[1]),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .col_left(col_left[1]),
    .col_right(col_right[1]), .col_x(col_x[1]), .col_y(col_y[1]), .col_last(col_last[1]),
    .col_valid(col_valid[1]), .col_ready(col_ready[1]));

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  obs_t exp_q   [2][$];
  obs_t obs_log [2][$];
  int   obs_cyc [2][$];
  bit   chk_en  [2];
  bit   held    [2];
  obs_t prev    [2];
  int   rdy_mode[2];
  int   k_acc   [2];
  int   img     [8][8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic obs_t cur(input int d);
    return {col_left[d], col_right[d], col_x[d], col_y[d], col_last[d]};
  endfunction

  function automatic obs_t log_at(input int d, input int idx);
    if (idx < obs_log[d].size()) return obs_log[d][idx];
    return '0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Output ready pattern per instance: 0 = always ready, 1 = random, 2 = stalled.
  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rdy_mode[d])
        0:       col_ready[d] = 1'b1;
        1:       col_ready[d] = ($urandom_range(0, 3) != 0);
        default: col_ready[d] = 1'b0;
      endcase
    end
  end

  // Compare process: handshake rule, hold stability, and every taken window.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      obs_t c;
      obs_t e;
      c = cur(d);
      if (rst_n) begin
        chk("pix_ready_rule", 128'(pix_ready[d]), 128'(!col_valid[d] || col_ready[d]));
        if (held[d]) chk("hold_stable", 128'(c), 128'(prev[d]));
        if (col_valid[d] && col_ready[d] && chk_en[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("unexpected_output", 128'(exp_q[d].size()), 128'(1));
          end else begin
            e = exp_q[d].pop_front();
            chk("window", 128'(c), 128'(e));
            obs_log[d].push_back(c);
            obs_cyc[d].push_back(cyc);
          end
        end
        held[d] = col_valid[d] && !col_ready[d];
        prev[d] = c;
      end else begin
        held[d] = 1'b0;
      end
    end
  end

  task automatic send(input int d, input logic [7:0] v, input logic s, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    pix_in[d]    = v;
    pix_sof[d]   = s;
    pix_valid[d] = 1'b1;
    t = 0;
    forever begin
      bit r;
      @(negedge clk);
      r = pix_ready[d];
      @(posedge clk);
      #1;
      if (r) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 128'(t), 128'(0));
        break;
      end
    end
    k_acc[d]     = cyc;
    pix_valid[d] = 1'b0;
    pix_sof[d]   = 1'b0;
  endtask

  // Expected windows come straight from the image: centres (1..w-2, 1..h-2).
  task automatic frame(input int d, input int w, input int h, input bit rnd, input int gapmax);
    int acc10;
    acc10 = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        img[y][x] = rnd ? int'($urandom_range(0, 255)) : 16 * y + x;
    for (int y = 1; y <= h - 2; y++) begin
      for (int x = 1; x <= w - 2; x++) begin
        obs_t e;
        e.l    = col_pack(8'(img[y-1][x-1]), 8'(img[y][x-1]), 8'(img[y+1][x-1]));
        e.r    = col_pack(8'(img[y-1][x+1]), 8'(img[y][x+1]), 8'(img[y+1][x+1]));
        e.x    = XW'(x);
        e.y    = XW'(y);
        e.last = (x == w - 2) && (y == h - 2);
        exp_q[d].push_back(e);
      end
    end
    for (int i = 0; i < w * h; i++) begin
      send(d, 8'(img[i / w][i % w]), (i == 0), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      if (i == 2 * w + 2) acc10 = k_acc[d];
    end
    k_acc[d] = acc10;
  endtask

  task automatic wait_drain(input int d);
    int t;
    t = 0;
    while ((exp_q[d].size() != 0 || col_valid[d]) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", 128'(exp_q[d].size()), 128'(0));
  endtask

  task automatic check_first(input string nm, input int base);
    obs_t f;
    f = log_at(0, base);
    chk({nm, "_left"},  128'(f.l), 128'(24'h001020));
    chk({nm, "_right"}, 128'(f.r), 128'(24'h021222));
    chk({nm, "_x"},     128'(f.x), 128'(1));
    chk({nm, "_y"},     128'(f.y), 128'(1));
    chk({nm, "_last"},  128'(f.last), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    obs_t f;
    for (int d = 0; d < 2; d++) begin
      pix_in[d] = '0; pix_sof[d] = 1'b0; pix_valid[d] = 1'b0; col_ready[d] = 1'b1;
      chk_en[d] = 1'b1; held[d] = 1'b0; rdy_mode[d] = 0; k_acc[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 128'(col_valid[d]), 128'(0));
      chk("reset_last",  128'(col_last[d]),  128'(0));
      chk("reset_left",  128'(col_left[d]),  128'(0));
      chk("reset_right", 128'(col_right[d]), 128'(0));
      chk("reset_xy",    128'({col_x[d], col_y[d]}), 128'(0));
    end
    rst_n = 1'b1;

    // Plain frame, always ready: first window, count, last flag, latency.
    base = obs_log[0].size();
    frame(0, 4, 4, 1'b0, 0);
    wait_drain(0);
    chk("frameA_count", 128'(obs_log[0].size() - base), 128'(4));
    check_first("frameA_first", base);
    f = log_at(0, base + 3);
    chk("frameA_last_flag", 128'(f.last), 128'(1));
    chk("frameA_last_xy", 128'({f.x, f.y}), 128'({10'd2, 10'd2}));
    chk("frameA_latency", 128'((obs_cyc[0].size() > base) ? obs_cyc[0][base] : -1), 128'(k_acc[0]));

    // Output stalled for 5 cycles mid-frame.
    base = obs_log[0].size();
    rdy_mode[0] = 2;
    fork
      frame(0, 4, 4, 1'b0, 0);
      begin
        int t;
        obs_t h;
        t = 0;
        while (!col_valid[0] && t < 300) begin
          @(negedge clk);
          t++;
        end
        chk("hold_reached", 128'(col_valid[0]), 128'(1));
        h = cur(0);
        repeat (5) begin
          @(negedge clk);
          chk("hold_pix_ready", 128'(pix_ready[0]), 128'(0));
          chk("hold_outputs", 128'(cur(0)), 128'(h));
        end
        rdy_mode[0] = 0;
      end
    join
    wait_drain(0);
    chk("frameB_count", 128'(obs_log[0].size() - base), 128'(4));

    // Pixels without a start-of-frame in IDLE are dropped.
    base = obs_log[0].size();
    for (int i = 0; i < 7; i++) send(0, 8'($urandom_range(0, 255)), 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_output", 128'(obs_log[0].size() - base), 128'(0));
    frame(0, 4, 4, 1'b0, 0);
    wait_drain(0);
    chk("frameC_count", 128'(obs_log[0].size() - base), 128'(4));

    // Restart after 9 pixels of an aborted frame.
    for (int i = 0; i < 9; i++) send(0, 8'($urandom_range(0, 255)), (i == 0), 0);
    base = obs_log[0].size();
    frame(0, 4, 4, 1'b0, 0);
    wait_drain(0);
    chk("frameD_count", 128'(obs_log[0].size() - base), 128'(4));
    check_first("frameD_first", base);

    // Asynchronous reset while an output is pending.
    chk_en[0] = 1'b0;
    for (int i = 0; i < 11; i++) send(0, 8'(16 * (i / 4) + i % 4), (i == 0), 0);
    chk("prereset_valid", 128'(col_valid[0]), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 128'(col_valid[0]), 128'(0));
    chk("async_reset_left", 128'(col_left[0]), 128'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk_en[0] = 1'b1;
    @(posedge clk);
    #1;
    base = obs_log[0].size();
    frame(0, 4, 4, 1'b0, 0);
    wait_drain(0);
    chk("frameE_count", 128'(obs_log[0].size() - base), 128'(4));
    check_first("frameE_first", base);

    // Randomized traffic on the 8x6 instance.
    rdy_mode[1] = 1;
    for (int fr = 0; fr < 3; fr++) begin
      base = obs_log[1].size();
      frame(1, 8, 6, 1'b1, 2);
      wait_drain(1);
      chk("rand_frame_count", 128'(obs_log[1].size() - base), 128'(24));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
